ccl_frame_sequencer: RTL and testbench

//  Drives one frame through the connected-components labeler: accepts a raster pixel stream, generates en/x/y.

---
 rtl/ccl_pkg.sv | 25 ++
 rtl/ccl_raster_counter.sv | 36 +++
 rtl/ccl_frame_sequencer.sv | 137 +++++++++++++
 tb/tb_ccl_frame_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ccl_pkg.sv
// Shared types for the connected-components labeler frame sequencer:
// FSM state encoding, label width and the object record layout.
package ccl_pkg;

    localparam int WORD_SIZE = 8;
    localparam logic [WORD_SIZE-1:0] MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_READ,
        S_WAIT_RD,
        S_PRESENT,
        S_DONE
    } ccl_state_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] id;
        logic [15:0]          x;
        logic [15:0]          y;
        logic                 last;
    } ccl_rec_t;

endpackage

// File: rtl/ccl_raster_counter.sv
// Raster x/y position counter: advances one pixel per accept, wraps at the
// end of each line and at the end of the frame, held at 0 while clear is high.
module ccl_raster_counter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance,
    input  logic        clear,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic        last
);

    logic x_end, y_end;

    assign x_end = (x == 16'(WIDTH - 1));
    assign y_end = (y == 16'(HEIGHT - 1));
    assign last  = x_end && y_end;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x_end) begin
                x <= '0;
                y <= y_end ? 16'd0 : y + 16'd1;
            end else begin
                x <= x + 16'd1;
            end
        end
    end

endmodule

// File: rtl/ccl_frame_sequencer.sv
// Frame sequencer for the CC labeler: raster scan, pipeline drain, then one
// centroid record per label. Optional sticky label_ovf via CCL_SEQ_LABEL_OVF_EN.
module ccl_frame_sequencer
    import ccl_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int WORD      = WORD_SIZE,
    parameter int DRAIN_CYC = 4,
    parameter int RD_LAT    = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            abort,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            ccl_en,
    output logic            ccl_flush,
    output logic [15:0]     x,
    output logic [15:0]     y,
    input  logic [WORD-1:0] num_labels,
    output logic [WORD-1:0] obj_id,
    input  logic [15:0]     obj_x,
    input  logic [15:0]     obj_y,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [WORD-1:0] out_id,
    output logic [15:0]     out_x,
    output logic [15:0]     out_y,
    output logic            out_last,
    output logic            busy,
    output logic            frame_done,
    output logic            label_ovf
);

    localparam int DW = $clog2(DRAIN_CYC + 1);
    localparam int RW = $clog2(RD_LAT + 2);

    ccl_state_e      state, state_nx;
    logic [DW-1:0]   drain_cnt;
    logic [RW-1:0]   rd_cnt;
    logic [WORD-1:0] n_obj, k;
    logic            accept, last_px, k_last;
    ccl_rec_t        rec;

    assign accept = in_ready && in_valid;
    // The labeler runs on every accepted pixel and on every drain cycle.
    assign ccl_en = accept || ccl_flush;
    assign k_last = (k == n_obj - WORD'(1));

    assign out_id   = rec.id;
    assign out_x    = rec.x;
    assign out_y    = rec.y;
    assign out_last = rec.last;

    ccl_raster_counter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_raster (
        .clk     (clk),
        .reset_n (reset_n),
        .advance (accept),
        .clear   (state != S_SCAN),
        .x       (x),
        .y       (y),
        .last    (last_px)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_SCAN;
            S_SCAN:    if (accept && last_px) state_nx = S_DRAIN;
            S_DRAIN:   if (drain_cnt == DW'(DRAIN_CYC - 1)) state_nx = S_READ;
            S_READ:    state_nx = (n_obj <= WORD'(1)) ? S_DONE : S_WAIT_RD;
            S_WAIT_RD: if (rd_cnt == RW'(RD_LAT)) state_nx = S_PRESENT;
            S_PRESENT: if (out_ready) state_nx = k_last ? S_DONE : S_WAIT_RD;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
        if (abort) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            in_ready   <= 1'b0;
            ccl_flush  <= 1'b0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            drain_cnt  <= '0;
            rd_cnt     <= '0;
            n_obj      <= '0;
            k          <= '0;
            obj_id     <= '0;
            rec        <= '0;
        end else begin
            state      <= state_nx;
            busy       <= (state_nx != S_IDLE);
            in_ready   <= (state_nx == S_SCAN);
            ccl_flush  <= (state_nx == S_DRAIN);
            out_valid  <= (state_nx == S_PRESENT);
            frame_done <= (state_nx == S_DONE);
            drain_cnt  <= (state == S_DRAIN) ? drain_cnt + DW'(1) : '0;
            rd_cnt     <= (state == S_WAIT_RD && state_nx == S_WAIT_RD) ? rd_cnt + RW'(1) : '0;

            if (state == S_DRAIN && state_nx == S_READ)
                n_obj <= num_labels;
            if (state == S_READ && state_nx == S_WAIT_RD) begin
                k      <= WORD'(1);
                obj_id <= WORD'(1);
            end
            // obj_x/obj_y have settled for obj_id after RD_LAT cycles.
            if (state == S_WAIT_RD && state_nx == S_PRESENT)
                rec <= '{id: k, x: obj_x, y: obj_y, last: k_last};
            if (state == S_PRESENT && state_nx == S_WAIT_RD) begin
                k      <= k + WORD'(1);
                obj_id <= k + WORD'(1);
            end
            if (state_nx == S_IDLE)
                obj_id <= '0;
        end
    end

`ifdef CCL_SEQ_LABEL_OVF_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            label_ovf <= 1'b0;
        else if (state == S_IDLE && start && !abort)
            label_ovf <= 1'b0;
        else if ((state == S_SCAN || state == S_DRAIN) && num_labels == MAX)
            label_ovf <= 1'b1;
    end
`else
    assign label_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ccl_frame_sequencer.sv
// Bench for ccl_frame_sequencer on a 4x3 frame with a registered data-table model.
module tb_ccl_frame_sequencer;

    localparam int W = 4;
    localparam int H = 3;
    localparam int DRAIN = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  num_labels = 8'd0;
    logic [15:0] obj_x, obj_y;
    logic        in_ready, ccl_en, ccl_flush, out_valid, out_last, busy, frame_done, label_ovf;
    logic [15:0] x, y, out_x, out_y;
    logic [7:0]  obj_id, out_id;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] nl;
        bit         gaps;
        int         stall_id;
        int         stall_cyc;
    } frame_t;

    typedef struct {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic        last;
    } rec_t;

    logic [31:0] pq[$];
    rec_t        rq[$];
    frame_t      tbl[5];

    ccl_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .WORD(8), .DRAIN_CYC(DRAIN), .RD_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .ccl_en(ccl_en), .ccl_flush(ccl_flush),
        .x(x), .y(y), .num_labels(num_labels), .obj_id(obj_id), .obj_x(obj_x), .obj_y(obj_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_x(out_x),
        .out_y(out_y), .out_last(out_last), .busy(busy), .frame_done(frame_done),
        .label_ovf(label_ovf)
    );

    always #5 clk = ~clk;

    // Data table with one cycle of read latency.
    always @(posedge clk) begin
        obj_x <= 16'h0100 + 16'(obj_id);
        obj_y <= 16'h0200 + 16'(obj_id) * 16'd3;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic run_frame(input frame_t f);
        int   flush_n, hs, last_flush, last_hs, done_cyc, stall_left;
        bit   done;
        rec_t r;
        logic [31:0] c;
        for (int yy = 0; yy < H; yy++)
            for (int xx = 0; xx < W; xx++)
                pq.push_back({16'(xx), 16'(yy)});
        for (int i = 1; i < int'(f.nl); i++)
            rq.push_back('{id: 8'(i), x: 16'h0100 + 16'(i), y: 16'h0200 + 16'(i) * 16'd3,
                           last: (i == int'(f.nl) - 1)});
        num_labels = f.nl;
        stall_left = f.stall_cyc;
        flush_n = 0; hs = 0; done = 0; last_flush = -1; last_hs = -1; done_cyc = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            in_valid = f.gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (out_valid && int'(out_id) == f.stall_id && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = f.gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            if (in_ready) chk("ccl_en_eq_accept", ccl_en, in_valid);
            if (in_ready && in_valid) begin
                if (pq.size() == 0) note_fail("extra_pixel");
                else begin
                    c = pq.pop_front();
                    chk("pixel_xy", {x, y}, c);
                end
            end
            if (ccl_flush) begin
                flush_n++;
                last_flush = cyc;
                chk("drain_en_ready_xy", {ccl_en, in_ready, x, y}, {1'b1, 1'b0, 32'd0});
            end
            if (out_valid) begin
                if (rq.size() == 0) note_fail("extra_record");
                else begin
                    r = rq[0];
                    chk("record", {out_id, out_x, out_y, out_last}, {r.id, r.x, r.y, r.last});
                    if (out_ready) begin
                        void'(rq.pop_front());
                        hs++;
                        last_hs = cyc;
                    end
                end
            end
            if (frame_done) begin
                done = 1;
                done_cyc = cyc;
            end
            @(negedge clk);
        end
        chk("frame_done_seen", done, 1);
        chk("pixels_left", pq.size(), 0);
        chk("flush_cycles", flush_n, DRAIN);
        chk("handshakes", hs, (f.nl > 1) ? int'(f.nl) - 1 : 0);
        if (f.nl > 1) chk("done_after_last_hs", done_cyc - last_hs, 1);
        else          chk("done_after_drain", done_cyc - last_flush, 2);
        #1;
        chk("idle_after_frame", {busy, frame_done, out_valid}, 3'b000);
        pq.delete();
        rq.delete();
    endtask

    initial begin
        bit seen;
        tbl[0] = '{nl: 8'd4, gaps: 1'b0, stall_id: -1, stall_cyc: 0};
        tbl[1] = '{nl: 8'd4, gaps: 1'b1, stall_id: 2,  stall_cyc: 5};
        tbl[2] = '{nl: 8'd1, gaps: 1'b0, stall_id: -1, stall_cyc: 0};
        tbl[3] = '{nl: 8'd2, gaps: 1'b1, stall_id: -1, stall_cyc: 0};
        tbl[4] = '{nl: 8'd0, gaps: 1'b1, stall_id: -1, stall_cyc: 0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("reset_ctrl", {busy, in_ready, ccl_en, ccl_flush, out_valid, frame_done, label_ovf}, 7'd0);
        chk("reset_xy_obj", {x, y, obj_id}, 40'd0);
        chk("reset_record", {out_id, out_x, out_y, out_last}, 41'd0);

        foreach (tbl[i]) run_frame(tbl[i]);

        // Abort while a record is presented, with the label table full.
        num_labels = 8'd255;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            #1;
            if (out_valid) seen = 1;
            else @(negedge clk);
        end
        if (!seen) note_fail("abort_wait_out_valid");
        chk("abort_first_record", {out_id, out_last}, {8'd1, 1'b0});
`ifdef CCL_SEQ_LABEL_OVF_EN
        chk("ovf_set", label_ovf, 1'b1);
`else
        chk("ovf_tied_low", label_ovf, 1'b0);
`endif
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        #1;
        chk("abort_idle", {out_valid, busy, in_ready, ccl_flush}, 4'd0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (frame_done) seen = 1;
            @(negedge clk);
            #1;
        end
        chk("abort_no_frame_done", seen, 1'b0);
`ifdef CCL_SEQ_LABEL_OVF_EN
        chk("ovf_sticky_after_abort", label_ovf, 1'b1);
`else
        chk("ovf_low_after_abort", label_ovf, 1'b0);
`endif
        @(negedge clk);
        run_frame('{nl: 8'd3, gaps: 1'b0, stall_id: -1, stall_cyc: 0});
        chk("ovf_cleared_by_start", label_ovf, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
